// File: rtl/utils_pkg.sv
// Shared AXI4-Lite types, response codes and byte-lane helpers for the CSR blocks.
package utils_pkg;

    typedef logic [31:0] axi_addr_t;
    typedef logic [31:0] axi_data_t;
    typedef logic [3:0]  axi_strb_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [1:0]  axi_error_t;

    localparam axi_error_t AXI_OKAY   = 2'b00;
    localparam axi_error_t AXI_SLVERR = 2'b10;

    typedef struct packed {
        axi_id_t   awid;
        axi_addr_t awaddr;
        logic      awvalid;
        axi_data_t wdata;
        axi_strb_t wstrb;
        logic      wvalid;
        logic      bready;
        axi_id_t   arid;
        axi_addr_t araddr;
        logic      arvalid;
        logic      rready;
    } s_axil_mosi_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        axi_id_t    bid;
        axi_error_t bresp;
        logic       bvalid;
        logic       arready;
        axi_id_t    rid;
        axi_data_t  rdata;
        axi_error_t rresp;
        logic       rvalid;
    } s_axil_miso_t;

    function automatic axi_data_t strb_to_mask(input axi_strb_t strb);
        axi_data_t m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic axi_data_t merge_bytes(input axi_data_t old_val, input axi_data_t new_val,
                                              input axi_strb_t strb);
        axi_data_t m;
        m = strb_to_mask(strb);
        return (old_val & ~m) | (new_val & m);
    endfunction

    // Word index relative to the bank base; addresses below the base wrap to a huge index.
    function automatic logic [29:0] csr_index(input axi_addr_t addr, input axi_addr_t base);
        axi_addr_t off;
        off = addr - base;
        return off[31:2];
    endfunction

endpackage

// File: rtl/eth_csr_irq.sv
// Sticky interrupt status (RW1C), interrupt mask (RW) and registered irq for the CSR bank.
module eth_csr_irq
    import utils_pkg::*;
#(
    parameter axi_data_t MASK_RST = 32'h0000_0000
)(
    input  logic      clk,
    input  logic      rst,
    input  logic      mask_we,
    input  logic      status_we,
    input  axi_data_t mask_wdata,
    input  axi_data_t clr_bits,
    input  axi_data_t irq_src_i,
    output axi_data_t status_q,
    output axi_data_t mask_q,
    output logic      irq_o
);

    axi_data_t status_r;
    axi_data_t mask_r;
    logic      irq_r;
    axi_data_t clr_s;

    // Clear bits only apply on a committed status write
    always_comb begin
        clr_s = 32'h0000_0000;
        if (status_we) begin
            clr_s = clr_bits;
        end else begin
            clr_s = 32'h0000_0000;
        end
    end

    // Set wins over clear so a source held high keeps its bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r <= 32'h0000_0000;
            mask_r   <= MASK_RST;
            irq_r    <= 1'b0;
        end else begin
            status_r <= (status_r & ~clr_s) | irq_src_i;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end
            irq_r <= |(status_r & mask_r);
        end
    end

    assign status_q = status_r;
    assign mask_q   = mask_r;
    assign irq_o    = irq_r;

endmodule

// File: rtl/eth_axil_csr_bank.sv
// AXI4-Lite CSR bank with independent AW/W capture and RO/RW registers.
// Define ETH_CSR_IRQ_EN to turn the top two registers into IRQ_MASK / IRQ_STATUS.
module eth_axil_csr_bank
    import utils_pkg::*;
#(
    parameter int unsigned         NUM_REGS  = 8,
    parameter axi_addr_t           BASE_ADDR = 32'h0000_0000,
    parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}},
    parameter axi_data_t           RST_VAL   = 32'h0000_0000
)(
    input  logic                         clk,
    input  logic                         rst,
    input  s_axil_mosi_t                 csr_mosi_i,
    output s_axil_miso_t                 csr_miso_o,
    input  axi_data_t [NUM_REGS-1:0]     hw_val_i,
    output axi_data_t [NUM_REGS-1:0]     reg_q_o,
    output logic      [NUM_REGS-1:0]     wr_pulse_o,
    input  axi_data_t                    irq_src_i,
    output logic                         irq_o
);

    localparam logic [29:0]         NUM_IDX = 30'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE_HOT = {{(NUM_REGS-1){1'b0}}, 1'b1};
`ifdef ETH_CSR_IRQ_EN
    localparam logic [NUM_REGS-1:0] IRQ_REGS = (ONE_HOT << (NUM_REGS-1)) | (ONE_HOT << (NUM_REGS-2));
`else
    localparam logic [NUM_REGS-1:0] IRQ_REGS = {NUM_REGS{1'b0}};
`endif
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~IRQ_REGS;

    logic        aw_held_r, w_held_r, bvalid_r, rvalid_r;
    axi_id_t     awid_r, bid_r, rid_r;
    axi_addr_t   awaddr_r;
    axi_data_t   wdata_r, rdata_r;
    axi_strb_t   wstrb_r;
    axi_error_t  bresp_r, rresp_r;
    logic [NUM_REGS-1:0] wr_pulse_r;
    axi_data_t [NUM_REGS-1:0] regs_r;

    logic        awready_s, wready_s, arready_s, aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    axi_addr_t   wr_addr_s;
    axi_id_t     wr_id_s;
    axi_data_t   wr_data_s, rd_data_s;
    axi_strb_t   wr_strb_s;
    logic [29:0] wr_idx_s, rd_idx_s;
    logic        wr_ro_s, wr_err_s, rd_err_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    axi_data_t [NUM_REGS-1:0] view_s;

    assign awready_s = !rst && !aw_held_r && !bvalid_r;
    assign wready_s  = !rst && !w_held_r && !bvalid_r;
    assign arready_s = !rst && !rvalid_r;
    assign aw_hs_s   = csr_mosi_i.awvalid && awready_s;
    assign w_hs_s    = csr_mosi_i.wvalid && wready_s;
    assign ar_hs_s   = csr_mosi_i.arvalid && arready_s;
    // Commit as soon as both halves are available, held or arriving this cycle
    assign commit_s  = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);

    // Write operands come from the holding registers once captured
    always_comb begin
        if (aw_held_r) begin
            wr_addr_s = awaddr_r;
            wr_id_s   = awid_r;
        end else begin
            wr_addr_s = csr_mosi_i.awaddr;
            wr_id_s   = csr_mosi_i.awid;
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = csr_mosi_i.wdata;
            wr_strb_s = csr_mosi_i.wstrb;
        end
    end

    assign wr_idx_s = csr_index(wr_addr_s, BASE_ADDR);
    assign rd_idx_s = csr_index(csr_mosi_i.araddr, BASE_ADDR);

    // Write decode: error on out-of-range or RO target, one-hot select otherwise
    always_comb begin
        wr_ro_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_ro_s = wr_ro_s | ((wr_idx_s == 30'(i)) & RO_EFF[i]);
        end
        wr_err_s = (wr_idx_s >= NUM_IDX) | wr_ro_s;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel_s[i] = commit_s & ~wr_err_s & (wr_idx_s == 30'(i));
        end
    end

`ifdef ETH_CSR_IRQ_EN
    axi_data_t irq_status_s;
    axi_data_t irq_mask_s;

    eth_csr_irq #(
        .MASK_RST (RST_VAL)
    ) u_irq (
        .clk        (clk),
        .rst        (rst),
        .mask_we    (wr_sel_s[NUM_REGS-2]),
        .status_we  (wr_sel_s[NUM_REGS-1]),
        .mask_wdata (merge_bytes(irq_mask_s, wr_data_s, wr_strb_s)),
        .clr_bits   (wr_data_s & strb_to_mask(wr_strb_s)),
        .irq_src_i  (irq_src_i),
        .status_q   (irq_status_s),
        .mask_q     (irq_mask_s),
        .irq_o      (irq_o)
    );
`else
    logic unused_irq_src_s;
    assign unused_irq_src_s = ^irq_src_i;
    assign irq_o = 1'b0;
`endif

    // Architectural view of every register as seen by reads and reg_q_o
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            view_s[i] = RO_EFF[i] ? hw_val_i[i] : regs_r[i];
        end
`ifdef ETH_CSR_IRQ_EN
        view_s[NUM_REGS-2] = irq_mask_s;
        view_s[NUM_REGS-1] = irq_status_s;
`endif
    end

    // Read mux; out-of-range reads return zero with SLVERR
    always_comb begin
        rd_data_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = rd_data_s | ((rd_idx_s == 30'(i)) ? view_s[i] : 32'h0000_0000);
        end
        rd_err_s = (rd_idx_s >= NUM_IDX);
    end

    // Write channel handshake, hold flags and B response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awid_r     <= 4'h0;
            awaddr_r   <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            wstrb_r    <= 4'h0;
            bvalid_r   <= 1'b0;
            bid_r      <= 4'h0;
            bresp_r    <= AXI_OKAY;
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bid_r     <= wr_id_s;
                bresp_r   <= wr_err_s ? AXI_SLVERR : AXI_OKAY;
            end else begin
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    awid_r    <= csr_mosi_i.awid;
                    awaddr_r  <= csr_mosi_i.awaddr;
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    wdata_r  <= csr_mosi_i.wdata;
                    wstrb_r  <= csr_mosi_i.wstrb;
                end
                if (bvalid_r && csr_mosi_i.bready) begin
                    bvalid_r <= 1'b0;
                end
            end
            wr_pulse_r <= wr_sel_s;
        end
    end

    // RW register storage with byte-lane merge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel_s[i] && !IRQ_REGS[i]) begin
                    regs_r[i] <= merge_bytes(regs_r[i], wr_data_s, wr_strb_s);
                end
            end
        end
    end

    // Read channel: data sampled from pre-write state on the AR handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            rresp_r  <= AXI_OKAY;
            rid_r    <= 4'h0;
        end else begin
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
                rresp_r  <= rd_err_s ? AXI_SLVERR : AXI_OKAY;
                rid_r    <= csr_mosi_i.arid;
            end else if (rvalid_r && csr_mosi_i.rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign csr_miso_o.awready = awready_s;
    assign csr_miso_o.wready  = wready_s;
    assign csr_miso_o.bid     = bid_r;
    assign csr_miso_o.bresp   = bresp_r;
    assign csr_miso_o.bvalid  = bvalid_r;
    assign csr_miso_o.arready = arready_s;
    assign csr_miso_o.rid     = rid_r;
    assign csr_miso_o.rdata   = rdata_r;
    assign csr_miso_o.rresp   = rresp_r;
    assign csr_miso_o.rvalid  = rvalid_r;
    assign reg_q_o            = view_s;
    assign wr_pulse_o         = wr_pulse_r;

endmodule

// File: tb/tb_eth_axil_csr_bank.sv
// Directed plus randomized bench for eth_axil_csr_bank against an array-based register model.
module tb_eth_axil_csr_bank;
    import utils_pkg::*;

    localparam int        N  = 8;
    localparam logic [N-1:0] RO = 8'b0000_1001;
    localparam axi_data_t RV = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    s_axil_mosi_t mosi;
    s_axil_miso_t miso;
    axi_data_t [N-1:0] hw_val;
    axi_data_t [N-1:0] reg_q;
    logic [N-1:0] wr_pulse;
    axi_data_t irq_src;
    logic irq;

    int checks = 0;
    int failures = 0;
    axi_data_t mdl [N];

    always #5 clk = ~clk;

    eth_axil_csr_bank #(
        .NUM_REGS (N),
        .BASE_ADDR(32'h0000_0000),
        .RO_MASK  (RO),
        .RST_VAL  (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_mosi_i(mosi),
        .csr_miso_o(miso),
        .hw_val_i  (hw_val),
        .reg_q_o   (reg_q),
        .wr_pulse_o(wr_pulse),
        .irq_src_i (irq_src),
        .irq_o     (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic axi_data_t m_merge(input axi_data_t old_v, input axi_data_t d, input axi_strb_t s);
        axi_data_t r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit m_err(input int idx);
        if (idx >= N) return 1'b1;
        return RO[idx];
    endfunction

    function automatic axi_data_t m_read(input int idx);
        if (idx >= N) return 32'h0;
        if (RO[idx]) return hw_val[idx];
        return mdl[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mdl[i] = RV;
`ifdef ETH_CSR_IRQ_EN
        mdl[N-1] = 32'h0;
`endif
    endtask

    task automatic axi_write(input string tag, input axi_addr_t addr, input axi_data_t data,
                             input axi_strb_t strb, input axi_id_t id,
                             input int aw_dly, input int w_dly, input int b_dly, input bit w1c);
        int idx;
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        logic [N-1:0] exp_pulse;
        idx = int'(addr[31:2]);
        exp_pulse = '0;
        if (!m_err(idx)) exp_pulse[idx] = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk);
            check({tag, "_no_early_b"}, miso.bvalid, 1'b0);
            if (w_done) check({tag, "_wready_held"}, miso.wready, 1'b0);
            if (aw_done) check({tag, "_awready_held"}, miso.awready, 1'b0);
            mosi.awvalid = !aw_done && cyc >= aw_dly;
            mosi.awaddr = addr; mosi.awid = id;
            mosi.wvalid = !w_done && cyc >= w_dly;
            mosi.wdata = data; mosi.wstrb = strb;
            #1;
            aw_hs = mosi.awvalid && miso.awready;
            w_hs = mosi.wvalid && miso.wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        check({tag, "_accepted"}, aw_done && w_done, 1'b1);
        @(negedge clk);
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
        if (!m_err(idx)) begin
            if (w1c) mdl[idx] = (mdl[idx] & ~m_merge(32'h0, data, strb)) | irq_src;
            else mdl[idx] = m_merge(mdl[idx], data, strb);
        end
        check({tag, "_bvalid"}, miso.bvalid, 1'b1);
        check({tag, "_bresp"}, miso.bresp, m_err(idx) ? AXI_SLVERR : AXI_OKAY);
        check({tag, "_bid"}, miso.bid, id);
        check({tag, "_pulse"}, wr_pulse, exp_pulse);
        if (idx < N) check({tag, "_regq"}, reg_q[idx], m_read(idx));
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_bhold"}, {miso.bvalid, miso.bid, miso.bresp}, {1'b1, id, m_err(idx) ? AXI_SLVERR : AXI_OKAY});
            check({tag, "_rdy_low"}, {miso.awready, miso.wready, wr_pulse}, {2'b00, {N{1'b0}}});
        end
        mosi.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        mosi.bready = 1'b0;
        check({tag, "_bdone"}, {miso.bvalid, wr_pulse}, {1'b0, {N{1'b0}}});
        check({tag, "_rdy_back"}, {miso.awready, miso.wready}, 2'b11);
    endtask

    task automatic axi_read(input string tag, input axi_addr_t addr, input axi_id_t id, input int r_dly);
        int idx;
        axi_data_t exp_d;
        axi_error_t exp_r;
        idx = int'(addr[31:2]);
        exp_d = m_read(idx);
        exp_r = (idx >= N) ? AXI_SLVERR : AXI_OKAY;
        @(negedge clk);
        mosi.arvalid = 1'b1; mosi.araddr = addr; mosi.arid = id;
        check({tag, "_arready"}, miso.arready, 1'b1);
        @(posedge clk); @(negedge clk);
        mosi.arvalid = 1'b0;
        check({tag, "_r"}, {miso.rvalid, miso.rid, miso.rresp, miso.rdata}, {1'b1, id, exp_r, exp_d});
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_rhold"}, {miso.rvalid, miso.arready, miso.rid, miso.rresp, miso.rdata},
                  {2'b10, id, exp_r, exp_d});
        end
        mosi.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        mosi.rready = 1'b0;
        check({tag, "_rdone"}, miso.rvalid, 1'b0);
    endtask

    initial begin
        int idx, op;
        axi_addr_t a;
        rst = 1'b1;
        mosi = '0;
        irq_src = 32'h0;
        for (int i = 0; i < N; i++) hw_val[i] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_readies", {miso.awready, miso.wready, miso.arready}, 3'b000);
        check("rst_valids", {miso.bvalid, miso.rvalid, irq, wr_pulse}, {3'b000, {N{1'b0}}});
        check("rst_regq1", reg_q[1], RV);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) axi_read("rst_rd", axi_addr_t'(i * 4), axi_id_t'(i), 0);

        // Partial strobe write, both channels together
        axi_write("strb", 32'h4, 32'hDEAD_BEEF, 4'b0011, 4'h5, 0, 0, 0, 1'b0);
        check("strb_val", reg_q[1], 32'hA5A5_BEEF);

        // W first, AW three cycles later, B backpressure
        axi_write("wfirst", 32'h8, 32'h1234_5678, 4'hF, 4'h9, 3, 0, 5, 1'b0);

        // RO write and out-of-range read
        axi_write("ro_wr", 32'h0, 32'hFFFF_FFFF, 4'hF, 4'h2, 0, 1, 0, 1'b0);
        check("ro_unchanged", reg_q[0], hw_val[0]);
        axi_read("oor_rd", axi_addr_t'(N * 4), 4'h3, 2);

        // Same-edge write commit and read of reg2
        axi_write("c_pre", 32'h8, 32'h0000_0011, 4'hF, 4'h1, 0, 0, 0, 1'b0);
        @(negedge clk);
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h8; mosi.awid = 4'h6;
        mosi.wvalid = 1'b1; mosi.wdata = 32'h0000_0022; mosi.wstrb = 4'hF;
        mosi.arvalid = 1'b1; mosi.araddr = 32'h8; mosi.arid = 4'hA;
        @(posedge clk); @(negedge clk);
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0; mosi.arvalid = 1'b0;
        check("conc_r", {miso.rvalid, miso.rdata}, {1'b1, 32'h0000_0011});
        check("conc_b", {miso.bvalid, miso.bresp, miso.bid}, {1'b1, AXI_OKAY, 4'h6});
        mdl[2] = 32'h0000_0022;
        mosi.bready = 1'b1; mosi.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        mosi.bready = 1'b0; mosi.rready = 1'b0;
        check("conc_done", {miso.bvalid, miso.rvalid}, 2'b00);
        axi_read("conc_post", 32'h8, 4'hB, 0);

        // Reset with a write and a read response pending
        @(negedge clk);
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h4; mosi.wvalid = 1'b1;
        mosi.wdata = 32'h5555_5555; mosi.wstrb = 4'hF;
        mosi.arvalid = 1'b1; mosi.araddr = 32'h4;
        @(posedge clk); @(negedge clk);
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b0; mosi.arvalid = 1'b0;
        check("mid_pending", {miso.bvalid, miso.rvalid, reg_q[1]}, {2'b11, 32'h5555_5555});
        #2 rst = 1'b1;
        #1;
        check("mid_rst", {miso.bvalid, miso.rvalid, miso.awready, miso.wready, miso.arready, wr_pulse},
              {5'b00000, {N{1'b0}}});
        check("mid_rst_ids", {miso.bid, miso.rid, miso.rdata, reg_q[1]}, {8'h00, 32'h0, RV});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_release", {miso.awready, miso.wready, miso.arready}, 3'b111);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 1);
            idx = $urandom_range(0, N + 1);
`ifdef ETH_CSR_IRQ_EN
            if (idx == N - 1) idx = N - 2;
`endif
            a = axi_addr_t'(idx * 4 + $urandom_range(0, 3));
            if (op == 0)
                axi_write("rnd_wr", a, $urandom, axi_strb_t'($urandom_range(0, 15)), axi_id_t'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
            else
                axi_read("rnd_rd", a, axi_id_t'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

`ifdef ETH_CSR_IRQ_EN
        axi_write("irq_mask", axi_addr_t'((N - 2) * 4), 32'h1, 4'hF, 4'h1, 0, 0, 0, 1'b0);
        @(negedge clk); irq_src = 32'h1;
        @(posedge clk); @(negedge clk); irq_src = 32'h0;
        check("irq_status_set", {reg_q[N-1][0], irq}, 2'b10);
        @(posedge clk); @(negedge clk);
        check("irq_rise", irq, 1'b1);
        mdl[N-1] = 32'h1;
        irq_src = 32'h1;
        axi_write("irq_w1c_hold", axi_addr_t'((N - 1) * 4), 32'h1, 4'hF, 4'h2, 0, 0, 0, 1'b1);
        check("irq_hold", {reg_q[N-1][0], irq}, 2'b11);
        irq_src = 32'h0;
        axi_write("irq_w1c", axi_addr_t'((N - 1) * 4), 32'h1, 4'hF, 4'h3, 0, 0, 0, 1'b1);
        check("irq_fall", {reg_q[N-1][0], irq}, 2'b00);
`else
        @(negedge clk); irq_src = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("irq_off", {irq, reg_q[N-1]}, {1'b0, mdl[N-1]});
        irq_src = 32'h0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
